pipeline_arbiter: RTL and testbench
===================================

Name: pipeline_arbiter

Overview:
- Shares one pipeline input port among NUM_REQ independent requesters using round-robin arbitration.
- Sits directly in front of the pipeline and drives its address/id/valid input, observing its stall output.
- Holds one registered output slot. Each granted request is tagged with its source index so the return path can route results.
- Per-requester enable mask is provided for software/config isolation.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- SRC_WIDTH, $clog2(NUM_REQ), width of source index tag
- `ADDRESS_WIDTH / `ID_WIDTH, from defines.vh, payload widths (not overridable here)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; state cleared while 0
- req_address  in  NUM_REQ*`ADDRESS_WIDTH  requester addresses, requester k at bits [k*AW +: AW]
- req_id  in  NUM_REQ*`ID_WIDTH  requester ids, same packing
- req_valid  in  NUM_REQ  per-requester valid
- req_stall  out  NUM_REQ  per-requester stall; requester must hold payload while valid && stall
- req_mask  in  NUM_REQ  1 = requester eligible; 0 = ignored (its stall held 1)
- out_address  out  `ADDRESS_WIDTH  to pipeline in_address
- out_id  out  `ID_WIDTH  to pipeline in_id
- out_src  out  SRC_WIDTH  index of requester that issued current output
- out_valid  out  1  to pipeline in_valid
- in_stall  in  1  from pipeline out_stall
- grant_count  out  16  total accepted transfers, saturating

Behaviour:
- Transfer rule, both sides: a beat moves when valid=1 and stall=0 in the same cycle.
- Reset (reset=0, async):
  - out_valid=0, out_address=0, out_id=0, out_src=0
  - rr pointer=0, grant_count=0
  - req_stall = all ones, so no requester is accepted during reset
  - On the first edge after deassertion, normal operation resumes.
- Reset mid-operation: the held output beat is dropped. Requesters see stall=1 throughout and must keep their beat until accepted.
- Slot readiness: slot_ready = !out_valid || !in_stall (combinational).
- Eligibility: eligible[k] = req_valid[k] && req_mask[k].
- Arbitration (combinational): winner = first eligible index scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1 (modulo NUM_REQ wrap).
- Stall outputs: req_stall[k] = !(slot_ready && any_eligible && winner==k). Non-winners, masked requesters and idle requesters see 1.
  - req_stall depends on in_stall combinationally. No register on the stall path, so this adds no latency.
- On accept (slot_ready && any_eligible), at the clock edge:
  - out_address/out_id are loaded from the winner and out_src=winner
  - out_valid=1
  - ptr = winner+1, wrapping NUM_REQ-1 -> 0
  - grant_count increments unless already 0xFFFF
- When slot_ready and nothing is eligible: out_valid goes to 0. Payload registers hold their value (don't-care); ptr is unchanged.
- When out_valid=1 and in_stall=1: all output registers hold and every req_stall=1.
- Latency: one cycle from requester accept to out_valid.
- Throughput: one beat per cycle while in_stall=0. Back-to-back grants between different requesters carry no bubble.
- Simultaneous drain and fill: the output is consumed and the new winner is loaded in the same edge.
- Mask change: takes effect immediately in arbitration. A beat already in the output slot is unaffected.
- Fairness: with all NUM_REQ continuously eligible and in_stall=0, grants rotate 0,1,2,...,NUM_REQ-1,0,... Max wait for an eligible requester is NUM_REQ-1 grants.
- No combinational path from req_* to out_* (all outputs registered except req_stall).

Test Plan:
- Reset: hold reset=0 with req_valid=4'b1111 -> req_stall=4'b1111, out_valid=0, grant_count=0. Release reset -> the first grant goes to requester 0 one edge later (out_src=0, out_valid=1).
- Round-robin: all four valid with address=0x10*k, in_stall=0 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; out_address 0x00,0x10,0x20,0x30,...; grant_count=8.
- Backpressure: load req 2 (address 0xAB), then in_stall=1 for 5 cycles with req 1 valid -> out_address stays 0xAB, out_src stays 2, req_stall[1]=1. Drop in_stall -> req 1 accepted in the same cycle; next cycle out_src=1.
- Wrap and sparse: ptr=3, only req 1 valid -> req 1 granted, ptr becomes 2. Then only req 3 and req 0 valid -> req 3 granted first, then req 0.
- Mask: req_mask=4'b1011, all valid -> requester 2 is never granted and its req_stall stays 1. Grant order is 0,1,3,0,1,3.
- Async reset mid-stream: assert reset low between edges while out_valid=1 -> out_valid drops to 0 immediately (no clock edge) and grant_count=0. Held requester beats are accepted after release.

Source files
------------

// File: rtl/pipeline_arbiter.sv
// pipeline_arbiter: round-robin arbiter that shares one pipeline input port
// among NUM_REQ requesters and holds the granted beat in a single output slot.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-low reset
//   req_address/id    packed requester payloads, requester k at [k*W +: W]
//   req_valid         per-requester valid
//   req_mask          per-requester eligibility (0 = ignored, stall held 1)
//   req_stall         per-requester stall (combinational, follows in_stall)
//   out_address/id    registered payload driven into the pipeline
//   out_src           index of the requester that issued the current beat
//   out_valid         registered valid into the pipeline
//   in_stall          stall back from the pipeline
//   grant_count       saturating count of accepted transfers

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module pipeline_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SRC_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ*`ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*`ID_WIDTH-1:0]      req_id,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_stall,
  input  logic [NUM_REQ-1:0]                req_mask,
  output logic [`ADDRESS_WIDTH-1:0]         out_address,
  output logic [`ID_WIDTH-1:0]              out_id,
  output logic [SRC_WIDTH-1:0]              out_src,
  output logic                              out_valid,
  input  logic                              in_stall,
  output logic [15:0]                       grant_count
);

  localparam int unsigned AW = `ADDRESS_WIDTH;
  localparam int unsigned IW = `ID_WIDTH;
  localparam int unsigned CW = 16;

  // Unpacked views of the requester payload buses.
  logic [AW-1:0] addr_arr [NUM_REQ];
  logic [IW-1:0] id_arr   [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k] = req_address[k*AW +: AW];
    assign id_arr[k]   = req_id[k*IW +: IW];
  end

  logic [SRC_WIDTH-1:0] ptr;
  logic [NUM_REQ-1:0]   eligible;
  logic                 any_eligible;
  logic [SRC_WIDTH-1:0] winner;
  logic [SRC_WIDTH-1:0] ptr_next;
  logic                 slot_ready;
  logic                 accept;

  // The slot can take a new beat when empty or draining this cycle.
  assign slot_ready = !out_valid || !in_stall;
  assign eligible   = req_valid & req_mask;

  // Round-robin scan starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [SRC_WIDTH:0] sum;
    any_eligible = 1'b0;
    winner       = '0;
    sum          = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (SRC_WIDTH+1)'(i);
      if (sum >= (SRC_WIDTH+1)'(NUM_REQ)) begin
        sum = sum - (SRC_WIDTH+1)'(NUM_REQ);
      end
      if (!any_eligible && eligible[SRC_WIDTH'(sum)]) begin
        any_eligible = 1'b1;
        winner       = SRC_WIDTH'(sum);
      end
    end
  end

  // Reset gating keeps every requester stalled while reset is asserted.
  assign accept = reset && slot_ready && any_eligible;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stall
    assign req_stall[k] = !(accept && (winner == SRC_WIDTH'(k)));
  end

  assign ptr_next = (winner == SRC_WIDTH'(NUM_REQ - 1)) ? '0
                                                         : winner + SRC_WIDTH'(1);

  // Output slot, rr pointer and transfer counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_address <= '0;
      out_id      <= '0;
      out_src     <= '0;
      ptr         <= '0;
      grant_count <= '0;
    end else if (slot_ready) begin
      if (any_eligible) begin
        out_valid   <= 1'b1;
        out_address <= addr_arr[winner];
        out_id      <= id_arr[winner];
        out_src     <= winner;
        ptr         <= ptr_next;
        if (grant_count != {CW{1'b1}}) begin
          grant_count <= grant_count + CW'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed testbench for pipeline_arbiter with hand-computed expectations.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_pipeline_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = `ADDRESS_WIDTH;
  localparam int unsigned IW = `ID_WIDTH;
  localparam int unsigned SW = 2;

  logic               clk;
  logic               reset;
  logic [NR*AW-1:0]   req_address;
  logic [NR*IW-1:0]   req_id;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_stall;
  logic [NR-1:0]      req_mask;
  logic [AW-1:0]      out_address;
  logic [IW-1:0]      out_id;
  logic [SW-1:0]      out_src;
  logic               out_valid;
  logic               in_stall;
  logic [15:0]        grant_count;

  pipeline_arbiter #(.NUM_REQ(NR), .SRC_WIDTH(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_address (req_address),
    .req_id      (req_id),
    .req_valid   (req_valid),
    .req_stall   (req_stall),
    .req_mask    (req_mask),
    .out_address (out_address),
    .out_id      (out_id),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .in_stall    (in_stall),
    .grant_count (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_payload(input int k, input logic [AW-1:0] a, input logic [IW-1:0] id);
    req_address[k*AW +: AW] = a;
    req_id[k*IW +: IW]      = id;
  endtask

  task automatic check_out(input string tag, input int src, input logic [31:0] addr,
                           input int cnt);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".src"},   32'(out_src), 32'(src));
    check({tag, ".addr"},  32'(out_address), addr);
    check({tag, ".count"}, 32'(grant_count), 32'(cnt));
  endtask

  int mask_order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    reset       = 1'b0;
    req_valid   = 4'hF;
    req_mask    = 4'hF;
    in_stall    = 1'b0;
    req_address = '0;
    req_id      = '0;
    for (int k = 0; k < NR; k++) set_payload(k, AW'(32'h10 * k), IW'(k + 1));

    // Reset state with every requester valid.
    #12;
    check("rst.stall", 32'(req_stall), 32'hF);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.count", 32'(grant_count), 32'd0);
    check("rst.addr",  32'(out_address), 32'd0);
    check("rst.src",   32'(out_src), 32'd0);
    step();
    check("rst_hold.stall", 32'(req_stall), 32'hF);
    check("rst_hold.valid", 32'(out_valid), 32'd0);

    // Release: requester 0 wins immediately.
    reset = 1'b1;
    #1;
    check("rel.stall", 32'(req_stall), 32'hE);

    // Round robin with all four valid.
    for (int i = 0; i < 8; i++) begin
      step();
      check_out($sformatf("rr%0d", i), i % 4, 32'h10 * (i % 4), i + 1);
      check($sformatf("rr%0d.id", i), 32'(out_id), 32'((i % 4) + 1));
    end

    // Backpressure: load requester 2, then stall the pipeline.
    set_payload(2, AW'(32'hAB), IW'(3));
    req_valid = 4'b0100;
    #1;
    check("bp.load_stall", 32'(req_stall), 32'hB);
    step();
    check_out("bp.load", 2, 32'hAB, 9);
    in_stall  = 1'b1;
    req_valid = 4'b0010;
    #1;
    check("bp.stall_all", 32'(req_stall), 32'hF);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("bp.hold%0d", i), 2, 32'hAB, 9);
      check($sformatf("bp.hold%0d.stall", i), 32'(req_stall), 32'hF);
    end
    in_stall = 1'b0;
    #1;
    check("bp.release_stall", 32'(req_stall), 32'hD);
    step();
    check_out("bp.drain_fill", 1, 32'h10, 10);

    // Wrap and sparse patterns (ptr is 2 here).
    req_valid = 4'b0100;
    step();
    check_out("wrap.r2", 2, 32'hAB, 11);
    req_valid = 4'b0010;
    #1;
    check("wrap.r1_stall", 32'(req_stall), 32'hD);
    step();
    check_out("wrap.r1", 1, 32'h10, 12);
    req_valid = 4'b1001;
    #1;
    check("wrap.r3_stall", 32'(req_stall), 32'h7);
    step();
    check_out("wrap.r3", 3, 32'h30, 13);
    req_valid = 4'b0001;
    #1;
    check("wrap.r0_stall", 32'(req_stall), 32'hE);
    step();
    check_out("wrap.r0", 0, 32'h00, 14);
    req_valid = 4'b1000;
    step();
    check_out("wrap.r3b", 3, 32'h30, 15);
    req_valid = 4'b0000;
    #1;
    check("idle.stall", 32'(req_stall), 32'hF);
    step();
    check("idle.valid", 32'(out_valid), 32'd0);
    check("idle.count", 32'(grant_count), 32'd15);

    // Mask out requester 2 (ptr is 0 here).
    set_payload(2, AW'(32'h20), IW'(3));
    req_mask  = 4'b1011;
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("mask%0d.stall", i), 32'(req_stall),
            32'(4'hF & ~(4'b0001 << mask_order[i])));
      step();
      check_out($sformatf("mask%0d", i), mask_order[i], 32'h10 * mask_order[i], 16 + i);
    end

    // Asynchronous reset between edges while the slot is full.
    req_mask = 4'hF;
    #2;
    reset = 1'b0;
    #1;
    check("areset.valid", 32'(out_valid), 32'd0);
    check("areset.count", 32'(grant_count), 32'd0);
    check("areset.src",   32'(out_src), 32'd0);
    check("areset.stall", 32'(req_stall), 32'hF);
    #2;
    reset = 1'b1;
    step();
    check_out("areset.first", 0, 32'h00, 1);
    step();
    check_out("areset.second", 1, 32'h10, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
